// File: rtl/soc_system_pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: register map, CTRL/STATUS
// bit positions and FSM state encoding.
package soc_system_pio_seq_pkg;

  localparam int PAT_IDX_W = 4;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_STATUS = 5'd1;
  localparam logic [4:0] ADDR_PERIOD = 5'd2;
  localparam logic [4:0] ADDR_LENGTH = 5'd3;
  localparam logic [4:0] ADDR_MANUAL = 5'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Word addresses 16..31 select the pattern table
  function automatic logic is_pattern_addr(input logic [4:0] addr);
    return addr[4];
  endfunction

endpackage

// File: rtl/soc_system_pio_seq_ctrl_if.sv
// Avalon-MM slave bus bundle for the PIO sequencer.
interface soc_system_pio_seq_ctrl_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/soc_system_pio_seq_timer.sv
// Step-period down-counter: load has priority over decrement; zero flags expiry.
module soc_system_pio_seq_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                zero
);

  logic [PERIOD_W-1:0] count_r;

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= count_r - {{(PERIOD_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/soc_system_pio_seq_ctrl.sv
// PIO pattern sequencer: steps out_port through a 16-entry table, each entry
// held PERIOD+1 cycles, with one-shot or looping playback and a done interrupt.
module soc_system_pio_seq_ctrl
  import soc_system_pio_seq_pkg::*;
#(
  parameter int PAT_DEPTH = 16,
  parameter int PERIOD_W  = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  soc_system_pio_seq_ctrl_if.slave   bus,
  output logic [7:0]                 out_port,
  output logic                       irq
);

  state_t               state_r;
  logic [PAT_IDX_W-1:0] index_r;
  logic                 done_r;
  logic                 loop_r;
  logic                 irq_en_r;
  logic [PERIOD_W-1:0]  period_r;
  logic [PAT_IDX_W-1:0] length_r;
  logic [7:0]           manual_r;
  logic [7:0]           pattern_r [PAT_DEPTH];

  logic wr_s, ctrl_wr_s, start_s, stop_s, go_s, done_clr_s;
  logic run_s, timer_zero_s, load_s, en_s;

  assign wr_s       = bus.chipselect & ~bus.write_n;
  assign ctrl_wr_s  = wr_s & (bus.address == ADDR_CTRL);
  assign start_s    = ctrl_wr_s & bus.writedata[CTRL_START];
  assign stop_s     = ctrl_wr_s & bus.writedata[CTRL_STOP];
  assign go_s       = start_s & ~stop_s;
  assign done_clr_s = wr_s & (bus.address == ADDR_STATUS) & bus.writedata[STAT_DONE];
  assign run_s      = (state_r == ST_RUN);

  // Reload on (re)start or step expiry; a stop freezes the timer
  assign load_s = go_s | (run_s & timer_zero_s & ~stop_s);
  assign en_s   = run_s & ~timer_zero_s & ~stop_s;

  soc_system_pio_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .en       (en_s),
    .load_val (period_r),
    .zero     (timer_zero_s)
  );

  // Software-visible configuration registers and pattern table
  always_ff @(posedge clk) begin
    if (reset) begin
      loop_r   <= 1'b0;
      irq_en_r <= 1'b0;
      period_r <= '0;
      length_r <= '0;
      manual_r <= 8'h00;
      for (int i = 0; i < PAT_DEPTH; i++) pattern_r[i] <= 8'h00;
    end else if (wr_s && is_pattern_addr(bus.address)) begin
      pattern_r[bus.address[PAT_IDX_W-1:0]] <= bus.writedata[7:0];
    end else if (wr_s) begin
      case (bus.address)
        ADDR_CTRL: begin
          loop_r   <= bus.writedata[CTRL_LOOP];
          irq_en_r <= bus.writedata[CTRL_IRQ_EN];
        end
        ADDR_PERIOD: period_r <= bus.writedata[PERIOD_W-1:0];
        ADDR_LENGTH: length_r <= bus.writedata[PAT_IDX_W-1:0];
        ADDR_MANUAL: manual_r <= bus.writedata[7:0];
        default:     ;
      endcase
    end else begin
      loop_r <= loop_r;
    end
  end

  // Sequencer FSM; a hardware done-set is assigned last so it beats W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      index_r <= '0;
      done_r  <= 1'b0;
    end else begin
      if (done_clr_s) done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r <= ST_RUN;
            index_r <= '0;
          end
        end
        ST_RUN: begin
          if (stop_s) begin
            state_r <= ST_IDLE;
          end else if (start_s) begin
            index_r <= '0;
          end else if (timer_zero_s) begin
            if (index_r == length_r) begin
              index_r <= '0;
              if (!loop_r) begin
                index_r <= index_r;
                state_r <= ST_IDLE;
                done_r  <= 1'b1;
              end
            end else begin
              index_r <= index_r + {{(PAT_IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    bus.readdata = 32'h0000_0000;
    if (is_pattern_addr(bus.address)) begin
      bus.readdata = {24'h00_0000, pattern_r[bus.address[PAT_IDX_W-1:0]]};
    end else begin
      case (bus.address)
        ADDR_CTRL:   bus.readdata = {28'h000_0000, irq_en_r, 1'b0, loop_r, 1'b0};
        ADDR_STATUS: bus.readdata = {24'h00_0000, index_r, 2'b00, done_r, run_s};
        ADDR_PERIOD: bus.readdata = {{(32-PERIOD_W){1'b0}}, period_r};
        ADDR_LENGTH: bus.readdata = {28'h000_0000, length_r};
        ADDR_MANUAL: bus.readdata = {24'h00_0000, manual_r};
        default:     bus.readdata = 32'h0000_0000;
      endcase
    end
  end

  assign out_port = run_s ? pattern_r[index_r] : manual_r;
  assign irq      = done_r & irq_en_r;

endmodule

// File: tb/tb_soc_system_pio_seq_ctrl.sv
// Directed self-checking bench for soc_system_pio_seq_ctrl.
module tb_soc_system_pio_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  logic       irq;
  int         n_checks = 0;
  int         n_errors = 0;

  soc_system_pio_seq_ctrl_if bus_if();

  soc_system_pio_seq_ctrl #(.PAT_DEPTH(16), .PERIOD_W(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled at the next posedge, returns at the following negedge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    #1;
    chk(tag, bus_if.readdata, exp);
    bus_if.chipselect = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'h00_0000, out_port}, {24'h00_0000, exp});
  endtask

  initial begin
    logic [7:0] e8;
    reset = 1'b1;
    bus_if.address = 5'd0;
    bus_if.writedata = 32'h0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_chk("reset_out", 8'h00);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rd_chk("reset_status", 5'd1, 32'h0);
    rd_chk("reset_ctrl", 5'd0, 32'h0);
    rd_chk("reset_pat0", 5'd16, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // One-shot walking-one sequence
    wr(5'd16, 32'h01); wr(5'd17, 32'h02); wr(5'd18, 32'h04); wr(5'd19, 32'h08);
    wr(5'd3, 32'd3); wr(5'd2, 32'd2); wr(5'd4, 32'hA5);
    out_chk("idle_manual", 8'hA5);
    wr(5'd0, 32'h1);
    for (int k = 0; k < 12; k++) begin
      e8 = 8'h01 << (k / 3);
      out_chk("oneshot_step", e8);
      if (k == 4) rd_chk("oneshot_busy", 5'd1, 32'h11);
      @(negedge clk);
    end
    out_chk("oneshot_end", 8'hA5);
    rd_chk("oneshot_status", 5'd1, 32'h32);
    chk("oneshot_irq_off", {31'h0, irq}, 32'h0);

    // Looping sequence stopped at cycle 20
    wr(5'd1, 32'h2);
    rd_chk("w1c_status", 5'd1, 32'h30);
    wr(5'd0, 32'h3);
    for (int k = 0; k < 20; k++) begin
      e8 = 8'h01 << ((k / 3) % 4);
      out_chk("loop_step", e8);
      @(negedge clk);
    end
    out_chk("loop_c20", 8'h04);
    wr(5'd0, 32'h4);
    out_chk("stop_out", 8'hA5);
    rd_chk("stop_status", 5'd1, 32'h20);

    // Interrupt behaviour
    wr(5'd0, 32'h9);
    repeat (12) @(negedge clk);
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(5'd1, 32'h2);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    wr(5'd0, 32'h9);
    repeat (11) @(negedge clk);
    out_chk("coinc_last", 8'h08);
    wr(5'd1, 32'h2);
    rd_chk("coinc_status", 5'd1, 32'h32);
    chk("coinc_irq", {31'h0, irq}, 32'h1);
    wr(5'd0, 32'h0);
    chk("irq_masked", {31'h0, irq}, 32'h0);
    wr(5'd1, 32'h2);

    // PERIOD=0 full-length sweep
    for (int i = 0; i < 16; i++) wr(5'(16 + i), 32'(i));
    wr(5'd2, 32'd0); wr(5'd3, 32'd15);
    wr(5'd0, 32'h1);
    for (int k = 0; k < 16; k++) begin
      out_chk("fast_step", 8'(k));
      rd_chk("fast_index", 5'd1, 32'((k << 4) | 1));
      @(negedge clk);
    end
    out_chk("fast_end", 8'hA5);
    rd_chk("fast_status", 5'd1, 32'hF2);

    // Start+stop together while idle, then reset mid-run
    wr(5'd1, 32'h2);
    wr(5'd0, 32'h5);
    rd_chk("startstop_status", 5'd1, 32'hF0);
    out_chk("startstop_out", 8'hA5);
    wr(5'd2, 32'd2); wr(5'd3, 32'd3);
    wr(5'd0, 32'h1);
    repeat (6) @(negedge clk);
    out_chk("pre_reset_out", 8'h02);
    rd_chk("pre_reset_status", 5'd1, 32'h21);
    reset = 1'b1;
    @(negedge clk);
    out_chk("midrun_reset_out", 8'h00);
    rd_chk("midrun_reset_status", 5'd1, 32'h0);
    chk("midrun_reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Field widths, unused addresses
    wr(5'd4, 32'hFFFF_FF3C); wr(5'd2, 32'hFFFF_FFFF); wr(5'd3, 32'hFFFF_FFF2);
    wr(5'd0, 32'hFFFF_FFFE);
    rd_chk("period_width", 5'd2, 32'h00FF_FFFF);
    rd_chk("length_width", 5'd3, 32'h2);
    rd_chk("manual_width", 5'd4, 32'h3C);
    rd_chk("ctrl_readback", 5'd0, 32'hA);
    rd_chk("ctrl_stop_idle", 5'd1, 32'h0);
    rd_chk("addr5_read", 5'd5, 32'h0);
    rd_chk("addr15_read", 5'd15, 32'h0);
    wr(5'd5, 32'hFFFF_FFFF); wr(5'd15, 32'hFFFF_FFFF);
    rd_chk("addr5_after", 5'd5, 32'h0);
    rd_chk("addr15_after", 5'd15, 32'h0);
    rd_chk("ctrl_after", 5'd0, 32'hA);
    rd_chk("status_after", 5'd1, 32'h0);
    rd_chk("manual_after", 5'd4, 32'h3C);
    out_chk("out_after", 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
